// File: rtl/traffic_ctrl_n_if.sv
// Signal bundle for the N-road traffic-light controller.
// The master side drives run enable, demand and emergency requests.
// The slave side (the controller) returns lamp codes and phase status.
interface traffic_ctrl_n_if #(
  parameter int NUM_ROADS = 4,
  parameter int ROAD_W    = $clog2(NUM_ROADS)
);
  logic                   en;
  logic [NUM_ROADS-1:0]   road_req;
  logic                   emg_req;
  logic [ROAD_W-1:0]      emg_road;
  logic [2*NUM_ROADS-1:0] light;
  logic [ROAD_W-1:0]      active_road;
  logic [1:0]             phase;
  logic                   emg_active;

  modport master (
    output en, road_req, emg_req, emg_road,
    input  light, active_road, phase, emg_active
  );

  modport slave (
    input  en, road_req, emg_req, emg_road,
    output light, active_road, phase, emg_active
  );
endinterface

// File: rtl/traffic_ctrl_n.sv
// N-road traffic-light controller: GREEN -> YELLOW -> ALLRED rotation with
// demand-driven round-robin road selection, green extension when no other
// road wants service, and emergency pre-emption toward a requested road.
module traffic_ctrl_n #(
  parameter int NUM_ROADS   = 4,
  parameter int GREEN_TIME  = 7,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int CNT_W       = 6,
  parameter int ROAD_W      = $clog2(NUM_ROADS)
) (
  input logic              clk,
  input logic              rst,
  traffic_ctrl_n_if.slave  bus
);

  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_ALLRED = 2'b10
  } phase_e;

  localparam int unsigned      ROADS_U     = 32'(NUM_ROADS);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TIME - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TIME - 1);
  localparam logic [1:0]       LAMP_RED    = 2'b00;
  localparam logic [1:0]       LAMP_YELLOW = 2'b01;
  localparam logic [1:0]       LAMP_GREEN  = 2'b10;

  phase_e              r_phase;
  phase_e              w_phase_nxt;
  logic [ROAD_W-1:0]   r_active;
  logic [ROAD_W-1:0]   w_active_nxt;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_count_nxt;
  logic [ROAD_W-1:0]   r_next;
  logic [ROAD_W-1:0]   w_next_nxt;
  logic                r_emg;
  logic                w_emg_nxt;

  logic                w_emg_valid;
  logic [NUM_ROADS-1:0] w_cand;
  logic [ROAD_W-1:0]   w_probe;
  logic [ROAD_W-1:0]   w_pick;
  logic                w_found;

  // An out-of-range emergency road is treated as no request; with a
  // power-of-two road count every encodable index is valid.
  generate
    if ((1 << ROAD_W) == NUM_ROADS) begin : g_emg_full
      assign w_emg_valid = bus.emg_req;
    end else begin : g_emg_range
      assign w_emg_valid = bus.emg_req && (32'(bus.emg_road) < ROADS_U);
    end
  endgenerate

  // Round-robin pick: first demanding road after the active one, wrapping.
  always_comb begin
    w_cand           = bus.road_req;
    w_cand[r_active] = 1'b0;
    w_found          = 1'b0;
    w_pick           = '0;
    w_probe          = '0;
    for (int unsigned k = 1; k < ROADS_U; k++) begin
      w_probe = ROAD_W'((32'(r_active) + k) % ROADS_U);
      if (!w_found && w_cand[w_probe]) begin
        w_found = 1'b1;
        w_pick  = w_probe;
      end
    end
  end

  // Phase/state register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase  <= PH_GREEN;
      r_active <= '0;
      r_count  <= '0;
      r_next   <= '0;
      r_emg    <= 1'b0;
    end else begin
      r_phase  <= w_phase_nxt;
      r_active <= w_active_nxt;
      r_count  <= w_count_nxt;
      r_next   <= w_next_nxt;
      r_emg    <= w_emg_nxt;
    end
  end

  // Next-state logic: en gates everything, emergency outranks normal timing.
  always_comb begin
    w_phase_nxt  = r_phase;
    w_active_nxt = r_active;
    w_count_nxt  = r_count;
    w_next_nxt   = r_next;
    w_emg_nxt    = r_emg;
    if (bus.en) begin
      case (r_phase)
        PH_GREEN: begin
          if (w_emg_valid && (bus.emg_road != r_active)) begin
            w_phase_nxt = PH_YELLOW;
            w_count_nxt = '0;
            w_next_nxt  = bus.emg_road;
            w_emg_nxt   = 1'b1;
          end else if (w_emg_valid) begin
            // Emergency already owns green: hold, parking the counter at the
            // decision point so release exits on its first free cycle.
            w_emg_nxt = 1'b1;
            if (r_count != GREEN_LAST) begin
              w_count_nxt = r_count + 1'b1;
            end
          end else begin
            w_emg_nxt = 1'b0;
            if (r_count == GREEN_LAST) begin
              w_count_nxt = '0;
              if (w_found) begin
                w_phase_nxt = PH_YELLOW;
                w_next_nxt  = w_pick;
              end
            end else begin
              w_count_nxt = r_count + 1'b1;
            end
          end
        end
        PH_YELLOW: begin
          if (w_emg_valid) begin
            w_next_nxt = bus.emg_road;
            w_emg_nxt  = 1'b1;
          end
          if (r_count == YELLOW_LAST) begin
            w_phase_nxt = PH_ALLRED;
            w_count_nxt = '0;
          end else begin
            w_count_nxt = r_count + 1'b1;
          end
        end
        PH_ALLRED: begin
          if (w_emg_valid) begin
            w_next_nxt = bus.emg_road;
            w_emg_nxt  = 1'b1;
          end
          if (r_count == ALLRED_LAST) begin
            // An emergency arriving on the last all-red cycle wins the grant.
            w_phase_nxt  = PH_GREEN;
            w_active_nxt = w_emg_valid ? bus.emg_road : r_next;
            w_count_nxt  = '0;
          end else begin
            w_count_nxt = r_count + 1'b1;
          end
        end
        default: begin
          w_phase_nxt = PH_GREEN;
          w_count_nxt = '0;
        end
      endcase
    end
  end

  // Lamp decode: only the active road can be non-RED, never during ALLRED.
  always_comb begin
    bus.light = '0;
    for (int unsigned i = 0; i < ROADS_U; i++) begin
      if (ROAD_W'(i) == r_active) begin
        case (r_phase)
          PH_GREEN:  bus.light[2*i +: 2] = LAMP_GREEN;
          PH_YELLOW: bus.light[2*i +: 2] = LAMP_YELLOW;
          default:   bus.light[2*i +: 2] = LAMP_RED;
        endcase
      end
    end
  end

  // Status outputs straight from the registered state.
  always_comb begin
    bus.phase       = r_phase;
    bus.active_road = r_active;
    bus.emg_active  = r_emg;
  end

endmodule
